// File: rtl/lvds_channel_sequencer.sv
// Steps an LVDS line selector through the enabled channels of a latched mask,
// holding each channel for a dwell time followed by an optional all-off guard gap.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no scan in progress, waiting for start
// S_DWELL | channel j driven (ch_en=1) for the latched dwell length
// S_GAP   | guard interval after a channel, all lines off, j held
module lvds_channel_sequencer #(
    parameter int DWELL_W    = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic               clk_100Mz,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [7:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [2:0]         j,
    output logic               ch_en,
    output logic               busy,
    output logic               scan_done,
    output logic [15:0]        scan_cnt,
    output logic               err_mask_empty
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state,   w_state_nx;
    logic [2:0]         r_j,       w_j_nx;
    logic               r_ch_en,   w_ch_en_nx;
    logic               r_busy,    w_busy_nx;
    logic               r_done,    w_done_nx;
    logic               r_err,     w_err_nx;
    logic [15:0]        r_scan_cnt, w_scan_cnt_nx;
    logic [DWELL_W-1:0] r_dcnt,    w_dcnt_nx;
    logic [GAP_W-1:0]   r_gcnt,    w_gcnt_nx;
    logic [7:0]         r_mask,    w_mask_nx;
    logic [DWELL_W-1:0] r_dwell,   w_dwell_nx;
    logic               w_advance;
    logic [7:0]         w_above;

    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) idx = 3'(k);
        end
        return idx;
    endfunction

    // Down-counter reload value; a zero dwell still gives one active cycle.
    function automatic logic [DWELL_W-1:0] f_dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    // Enabled channels strictly above the current one.
    assign w_above = r_mask & (8'hFE << r_j);

    always_ff @(posedge clk_100Mz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_j        <= '0;
            r_ch_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_scan_cnt <= '0;
            r_dcnt     <= '0;
            r_gcnt     <= '0;
            r_mask     <= '0;
            r_dwell    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_j        <= w_j_nx;
            r_ch_en    <= w_ch_en_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
            r_scan_cnt <= w_scan_cnt_nx;
            r_dcnt     <= w_dcnt_nx;
            r_gcnt     <= w_gcnt_nx;
            r_mask     <= w_mask_nx;
            r_dwell    <= w_dwell_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_j_nx        = r_j;
        w_ch_en_nx    = r_ch_en;
        w_busy_nx     = r_busy;
        w_done_nx     = 1'b0;
        w_err_nx      = 1'b0;
        w_scan_cnt_nx = r_scan_cnt;
        w_dcnt_nx     = r_dcnt;
        w_gcnt_nx     = r_gcnt;
        w_mask_nx     = r_mask;
        w_dwell_nx    = r_dwell;
        w_advance     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (ch_mask != 8'h00) begin
                        w_mask_nx  = ch_mask;
                        w_dwell_nx = dwell_len;
                        w_state_nx = S_DWELL;
                        w_j_nx     = f_lowest(ch_mask);
                        w_ch_en_nx = 1'b1;
                        w_busy_nx  = 1'b1;
                        w_dcnt_nx  = f_dwell_load(dwell_len);
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                if (r_dcnt != '0) begin
                    w_dcnt_nx = r_dcnt - DWELL_W'(1);
                end else if (GAP_CYCLES > 0) begin
                    w_state_nx = S_GAP;
                    w_ch_en_nx = 1'b0;
                    w_gcnt_nx  = GAP_LOAD;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gcnt != '0) begin
                    w_gcnt_nx = r_gcnt - GAP_W'(1);
                end else begin
                    w_advance = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_advance) begin
            if (w_above != 8'h00) begin
                w_state_nx = S_DWELL;
                w_j_nx     = f_lowest(w_above);
                w_ch_en_nx = 1'b1;
                w_dcnt_nx  = f_dwell_load(r_dwell);
            end else begin
                w_done_nx     = 1'b1;
                w_scan_cnt_nx = r_scan_cnt + 16'd1;
                if (continuous) begin
                    w_state_nx = S_DWELL;
                    w_j_nx     = f_lowest(r_mask);
                    w_ch_en_nx = 1'b1;
                    w_dcnt_nx  = f_dwell_load(r_dwell);
                end else begin
                    w_state_nx = S_IDLE;
                    w_j_nx     = '0;
                    w_ch_en_nx = 1'b0;
                    w_busy_nx  = 1'b0;
                end
            end
        end

        // Abort overrides everything, including a coincident end of pass.
        if (stop && (r_state != S_IDLE)) begin
            w_state_nx    = S_IDLE;
            w_j_nx        = '0;
            w_ch_en_nx    = 1'b0;
            w_busy_nx     = 1'b0;
            w_done_nx     = 1'b0;
            w_scan_cnt_nx = r_scan_cnt;
        end
    end

    assign j              = r_j;
    assign ch_en          = r_ch_en;
    assign busy           = r_busy;
    assign scan_done      = r_done;
    assign scan_cnt       = r_scan_cnt;
    assign err_mask_empty = r_err;

endmodule

// File: doc/lvds_channel_sequencer.md
LVDS_CHANNEL_SEQUENCER -- requirements
Module: lvds_channel_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 16, the width of dwell_len and the dwell counter.
REQ-002 SHALL have parameter GAP_CYCLES, default 4, the number of all-lines-off guard cycles after each channel (0 = no gap).
REQ-003 SHALL have port clk_100Mz  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level, sampled each edge; begins a scan when idle.
REQ-006 SHALL have port stop  input  1  level, sampled each edge; aborts a scan.
REQ-007 SHALL have port continuous  input  1  1 = rescan after the last channel, 0 = single pass.
REQ-008 SHALL have port ch_mask  input  8  enabled LVDS channels, bit n = channel n.
REQ-009 SHALL have port dwell_len  input  DWELL_W  active cycles per channel.
REQ-010 SHALL have port j  output  3  channel index fed to the downstream LVDS line selector.
REQ-011 SHALL have port ch_en  output  1  high while channel j is driven.
REQ-012 SHALL have port busy  output  1  high while a scan is in progress.
REQ-013 SHALL have port scan_done  output  1  one-cycle pulse at completion of each pass.
REQ-014 SHALL have port scan_cnt  output  16  completed-pass counter.
REQ-015 SHALL have port err_mask_empty  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 SHALL implement exactly three states: IDLE, DWELL and GAP.
REQ-017 In IDLE, start=1, stop=0 and ch_mask!=0 SHALL, on that edge, latch ch_mask and dwell_len, enter DWELL, and set j to the lowest set mask bit, ch_en=1 and busy=1.
REQ-018 In IDLE, start=1, stop=0 and ch_mask==0 SHALL pulse err_mask_empty for one cycle and remain in IDLE.
REQ-019 Latched mask and dwell SHALL be used for the whole scan, including continuous passes; input changes during a scan SHALL be ignored until the next start from IDLE.
REQ-020 A latched dwell_len of 0 SHALL be treated as 1.
REQ-021 ch_en SHALL be high for exactly the latched dwell value of consecutive cycles per channel.
REQ-022 At the end of DWELL, the block SHALL enter GAP when GAP_CYCLES>0, with ch_en=0 and j held, for exactly GAP_CYCLES cycles.
REQ-023 With GAP_CYCLES=0, the block SHALL advance directly from DWELL, so that DWELL periods are back-to-back.
REQ-024 Advance SHALL select the next set latched-mask bit strictly above the current j, which then enters DWELL; disabled channels SHALL take zero cycles.
REQ-025 When no higher channel is enabled, the advance edge SHALL pulse scan_done for one cycle and increment scan_cnt, wrapping from 0xFFFF to 0.
REQ-026 In that same scan-end case with continuous=1 (sampled live on that edge), j SHALL wrap to the lowest enabled channel in DWELL.
REQ-027 In that same scan-end case with continuous=0, the block SHALL go to IDLE with busy=0, ch_en=0 and j=0.
REQ-028 stop=1 in DWELL or GAP SHALL, on that edge, go to IDLE with ch_en=0, busy=0 and j=0, with no scan_done and no scan_cnt change.
REQ-029 stop SHALL win over a simultaneous scan-end, pulsing no scan_done.
REQ-030 start while busy SHALL be ignored.
REQ-031 In IDLE, start and stop both high SHALL leave the block in IDLE with no error pulse.
REQ-032 ch_en=1 SHALL imply exactly one valid channel on j; j SHALL change only when ch_en=0 or on a direct channel-to-channel advance.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE with j=0, ch_en=0, busy=0, scan_done=0, err_mask_empty=0 and scan_cnt=0, regardless of state.
REQ-035 The latched mask and dwell SHALL be cleared to 0 on reset.
REQ-036 After rst_n deasserts, the first scan SHALL require a new start.

Verification
REQ-037 Bench SHALL cover: mask=0xFF, dwell=3, GAP=4, single, start -> j=0..7, each ch_en 3 cycles then 4 gap cycles, one scan_done, scan_cnt=1, busy low after channel 7's gap.
REQ-038 Bench SHALL cover: mask=0x82, dwell=2 -> only j=1 then j=7, with channel 7 following channel 1's gap immediately.
REQ-039 Bench SHALL cover: mask=0x00, start -> err_mask_empty high exactly one cycle, busy stays 0.
REQ-040 Bench SHALL cover: continuous=1, mask=0x05, dwell=1, GAP=0 -> j 0,2,0,2 with ch_en stuck high and scan_done every second cycle; then stop -> next edge ch_en=0, busy=0, scan_cnt frozen.
REQ-041 Bench SHALL cover: rst_n low mid-DWELL on channel 5 with scan_cnt=3 -> outputs zero without a clock edge, scan_cnt=0, idle until new start.
REQ-042 Bench SHALL cover: dwell_len=0 -> 1-cycle dwell; changing ch_mask and dwell_len mid-scan -> sequence and durations unchanged.
